// File: rtl/bit_population_pkg.sv
// ============================================================================
// bit_population_pkg : shared types and helpers for bit_population_generator
// Revision: 1.0
// ============================================================================
`default_nettype none

package bit_population_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam int MAX_WIDTH = 32;

   // Helpers work on MAX_WIDTH+1 bits; callers truncate to their own WIDTH.
   function automatic logic [MAX_WIDTH:0] first_word(input int unsigned n);
      first_word = (33'd1 << n) - 33'd1;
   endfunction

   function automatic logic [MAX_WIDTH:0] last_word(input int unsigned n,
                                                    input int unsigned width);
      last_word = first_word(n) << (width - n);
   endfunction

   function automatic logic [5:0] ctz(input logic [MAX_WIDTH:0] x);
      ctz = 6'(MAX_WIDTH + 1);
      for (int i = MAX_WIDTH; i >= 0; i--) begin
         if (x[i]) ctz = 6'(i);
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/bit_population_if.sv
// ============================================================================
// bit_population_if : request and word-stream handshakes of the generator
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bit_population_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
);
   logic [CNT_W-1:0] cnt_i;
   logic             cnt_val_i;
   logic             cnt_rdy_o;
   logic [WIDTH-1:0] data_o;
   logic             data_val_o;
   logic             data_last_o;
   logic             data_rdy_i;
   logic             err_o;

   modport master (
      output cnt_i, cnt_val_i, data_rdy_i,
      input  cnt_rdy_o, data_o, data_val_o, data_last_o, err_o
   );

   modport slave (
      input  cnt_i, cnt_val_i, data_rdy_i,
      output cnt_rdy_o, data_o, data_val_o, data_last_o, err_o
   );
endinterface

`default_nettype wire

// File: rtl/bit_population_generator_next.sv
// ============================================================================
// bit_pattern_next : combinational Gosper step, x -> next word, same popcount
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_pattern_next
   import bit_population_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x_i,
   output logic [WIDTH-1:0] next_o
);
   logic [WIDTH:0] x_ext;
   logic [WIDTH:0] low_bit;
   logic [WIDTH:0] ripple;
   logic [WIDTH:0] refill;

   // One spare bit holds the carry of the ripple; ctz replaces the divide.
   always_comb begin
      x_ext   = {1'b0, x_i};
      low_bit = x_ext & (-x_ext);
      ripple  = x_ext + low_bit;
      refill  = ((ripple ^ x_ext) >> 2) >> ctz(33'(x_ext));
      next_o  = WIDTH'(ripple | refill);
   end
endmodule

`default_nettype wire

// File: rtl/bit_population_generator.sv
// ============================================================================
// bit_population_generator : streams every WIDTH-bit word of popcount N
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_population_generator
   import bit_population_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic            clk_i,
   input  logic            arst_n_i,
   bit_population_if.slave bus
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             val_q, val_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] next_word;
   logic             is_last;

   bit_pattern_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .x_i    (data_q),
      .next_o (next_word)
   );

   assign is_last         = (data_q == WIDTH'(last_word(32'(cnt_q), WIDTH)));
   assign bus.cnt_rdy_o   = (state_q == IDLE);
   assign bus.data_o      = data_q;
   assign bus.data_val_o  = val_q;
   assign bus.data_last_o = val_q && is_last;
   assign bus.err_o       = err_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      val_d   = val_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.cnt_val_i) begin
               if (32'(bus.cnt_i) > 32'(WIDTH)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = STREAM;
                  cnt_d   = bus.cnt_i;
                  data_d  = WIDTH'(first_word(32'(bus.cnt_i)));
                  val_d   = 1'b1;
               end
            end
         end
         STREAM: begin
            // The step is never taken from the last word, so its carry is dropped.
            if (bus.data_rdy_i) begin
               if (is_last) begin
                  state_d = IDLE;
                  val_d   = 1'b0;
                  data_d  = '0;
               end else begin
                  data_d  = next_word;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         val_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         val_q   <= val_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_bit_population_generator.sv
// ============================================================================
// tb_bit_population_generator : directed self-checking bench, WIDTH = 8
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bit_population_generator;
   logic clk;
   logic arst_n;
   int   errors;
   int   checks;

   bit_population_if #(.WIDTH(8)) bus ();

   bit_population_generator #(.WIDTH(8)) dut (
      .clk_i    (clk),
      .arst_n_i (arst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next larger 8-bit value with popcount n (brute-force reference).
   function automatic logic [7:0] ref_next(input logic [7:0] x, input int n);
      ref_next = 8'h00;
      for (int y = int'(x) + 1; y < 256; y++) begin
         logic [7:0] v;
         v = 8'(y);
         if ($countones(v) == n) return v;
      end
   endfunction

   task automatic request(input int n);
      bus.cnt_i     = 4'(n);
      bus.cnt_val_i = 1'b1;
      @(negedge clk);
      bus.cnt_val_i = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.data_val_o !== 1'b0 || bus.data_o !== 8'h00 || bus.data_last_o !== 1'b0 ||
          bus.err_o !== 1'b0 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: val=%b data=%h last=%b err=%b rdy=%b, required 0 00 0 0 1",
                  bus.data_val_o, bus.data_o, bus.data_last_o, bus.err_o, bus.cnt_rdy_o);
      end
   endtask

   task automatic test_n2_stream();
      logic [7:0] exp;
      int words;
      exp = 8'h03;
      words = 0;
      bus.data_rdy_i = 1'b1;
      request(2);
      checks++;
      if (bus.cnt_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL n2_busy_rdy: cnt_rdy=%b, required 0", bus.cnt_rdy_o);
      end
      for (int k = 0; k < 40; k++) begin
         if (bus.data_val_o !== 1'b1) break;
         checks++;
         if (bus.data_o !== exp || bus.data_last_o !== (exp == 8'hC0)) begin
            errors++;
            $display("FAIL n2_word%0d: data=%h last=%b, required %h %b",
                     k, bus.data_o, bus.data_last_o, exp, exp == 8'hC0);
         end
         words++;
         exp = ref_next(exp, 2);
         @(negedge clk);
      end
      checks++;
      if (words != 28 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL n2_count: words=%0d rdy=%b, required 28 1", words, bus.cnt_rdy_o);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp;
      int words;
      exp = 8'h07;
      words = 0;
      request(3);
      for (int k = 0; k < 80; k++) begin
         if (bus.data_val_o !== 1'b1) break;
         if (k == 1) begin
            bus.data_rdy_i = 1'b0;
            for (int s = 0; s < 4; s++) begin
               checks++;
               if (bus.data_o !== 8'h0B || bus.data_val_o !== 1'b1 || bus.data_last_o !== 1'b0) begin
                  errors++;
                  $display("FAIL n3_hold%0d: data=%h val=%b last=%b, required 0b 1 0",
                           s, bus.data_o, bus.data_val_o, bus.data_last_o);
               end
               @(negedge clk);
            end
            bus.data_rdy_i = 1'b1;
         end
         checks++;
         if (bus.data_o !== exp || bus.data_last_o !== (exp == 8'hE0)) begin
            errors++;
            $display("FAIL n3_word%0d: data=%h last=%b, required %h %b",
                     k, bus.data_o, bus.data_last_o, exp, exp == 8'hE0);
         end
         words++;
         exp = ref_next(exp, 3);
         @(negedge clk);
      end
      checks++;
      if (words != 56) begin
         errors++;
         $display("FAIL n3_count: words=%0d, required 56", words);
      end
   endtask

   task automatic test_single_words();
      request(0);
      checks++;
      if (bus.data_val_o !== 1'b1 || bus.data_o !== 8'h00 || bus.data_last_o !== 1'b1) begin
         errors++;
         $display("FAIL n0_word: val=%b data=%h last=%b, required 1 00 1",
                  bus.data_val_o, bus.data_o, bus.data_last_o);
      end
      @(negedge clk);
      checks++;
      if (bus.data_val_o !== 1'b0 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL n0_done: val=%b rdy=%b, required 0 1", bus.data_val_o, bus.cnt_rdy_o);
      end
      request(8);
      checks++;
      if (bus.data_val_o !== 1'b1 || bus.data_o !== 8'hFF || bus.data_last_o !== 1'b1) begin
         errors++;
         $display("FAIL n8_word: val=%b data=%h last=%b, required 1 ff 1",
                  bus.data_val_o, bus.data_o, bus.data_last_o);
      end
      @(negedge clk);
      checks++;
      if (bus.data_val_o !== 1'b0 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL n8_done: val=%b rdy=%b, required 0 1", bus.data_val_o, bus.cnt_rdy_o);
      end
   endtask

   task automatic test_error();
      checks++;
      if (bus.err_o !== 1'b0) begin
         errors++;
         $display("FAIL err_idle: err=%b, required 0", bus.err_o);
      end
      request(9);
      checks++;
      if (bus.err_o !== 1'b1 || bus.data_val_o !== 1'b0 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL err_pulse: err=%b val=%b rdy=%b, required 1 0 1",
                  bus.err_o, bus.data_val_o, bus.cnt_rdy_o);
      end
      @(negedge clk);
      checks++;
      if (bus.err_o !== 1'b0 || bus.data_val_o !== 1'b0 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL err_clear: err=%b val=%b rdy=%b, required 0 0 1",
                  bus.err_o, bus.data_val_o, bus.cnt_rdy_o);
      end
   endtask

   task automatic test_reset_mid_stream();
      logic [7:0] exp_n4 [5] = '{8'h0F, 8'h17, 8'h1B, 8'h1D, 8'h1E};
      logic [7:0] exp;
      request(4);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.data_val_o !== 1'b1 || bus.data_o !== exp_n4[k]) begin
            errors++;
            $display("FAIL n4_word%0d: val=%b data=%h, required 1 %h",
                     k, bus.data_val_o, bus.data_o, exp_n4[k]);
         end
         @(negedge clk);
      end
      arst_n = 1'b0;
      #1;
      checks++;
      if (bus.data_val_o !== 1'b0 || bus.data_o !== 8'h00 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: val=%b data=%h rdy=%b, required 0 00 1",
                  bus.data_val_o, bus.data_o, bus.cnt_rdy_o);
      end
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      request(1);
      exp = 8'h01;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus.data_val_o !== 1'b1 || bus.data_o !== exp || bus.data_last_o !== (k == 7)) begin
            errors++;
            $display("FAIL n1_word%0d: val=%b data=%h last=%b, required 1 %h %b",
                     k, bus.data_val_o, bus.data_o, bus.data_last_o, exp, k == 7);
         end
         exp = exp << 1;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      bus.cnt_i     = 4'd1;
      bus.cnt_val_i = 1'b1;
      @(negedge clk);
      bus.cnt_i = 4'd7;
      exp = 8'h01;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus.data_val_o !== 1'b1 || bus.data_o !== exp || bus.cnt_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_n1_word%0d: val=%b data=%h rdy=%b, required 1 %h 0",
                     k, bus.data_val_o, bus.data_o, bus.cnt_rdy_o, exp);
         end
         exp = exp << 1;
         @(negedge clk);
      end
      checks++;
      if (bus.cnt_rdy_o !== 1'b1 || bus.data_val_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: rdy=%b val=%b, required 1 0", bus.cnt_rdy_o, bus.data_val_o);
      end
      @(negedge clk);
      bus.cnt_val_i = 1'b0;
      exp = 8'h7F;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus.data_val_o !== 1'b1 || bus.data_o !== exp || bus.data_last_o !== (exp == 8'hFE)) begin
            errors++;
            $display("FAIL b2b_n7_word%0d: val=%b data=%h last=%b, required 1 %h %b",
                     k, bus.data_val_o, bus.data_o, bus.data_last_o, exp, exp == 8'hFE);
         end
         exp = ref_next(exp, 7);
         @(negedge clk);
      end
      checks++;
      if (bus.data_val_o !== 1'b0 || bus.cnt_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_end: val=%b rdy=%b, required 0 1", bus.data_val_o, bus.cnt_rdy_o);
      end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      arst_n        = 1'b0;
      bus.cnt_i     = '0;
      bus.cnt_val_i = 1'b0;
      bus.data_rdy_i = 1'b1;
      @(negedge clk);
      test_reset();
      arst_n = 1'b1;
      @(negedge clk);
      test_n2_stream();
      test_backpressure();
      test_single_words();
      test_error();
      test_reset_mid_stream();
      @(negedge clk);
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire

// File: doc/bit_population_generator.md
Name: bit_population_generator

Overview:
Inverse companion of the bit population counter. It accepts a requested population count N. It then streams every WIDTH-bit word containing exactly N set bits, in ascending numeric order, one word per accepted handshake. It serves as the stimulus/pattern source in front of the counter path, and as a standalone combination enumerator.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), width of the count input; derived, do not override.

Ports:
clk_i  input  1  clock
arst_n_i  input  1  asynchronous active-low reset
cnt_i  input  CNT_W  requested population count N
cnt_val_i  input  1  cnt_i valid
cnt_rdy_o  output  1  block ready to accept a new request
data_o  output  WIDTH  current word with popcount N
data_val_o  output  1  data_o valid
data_last_o  output  1  data_o is the final word of the sequence
data_rdy_i  input  1  downstream accepts data_o
err_o  output  1  one-cycle pulse: illegal request (N > WIDTH)

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low on arst_n_i. While reset is asserted: state=IDLE, data_o=0, data_val_o=0, data_last_o=0, err_o=0, cnt_rdy_o=1.
- cnt_rdy_o = (state==IDLE). It is combinational from the state register only, never from cnt_val_i.
- Handshakes: a request is accepted on a clock edge with cnt_val_i && cnt_rdy_o. A word is consumed on a clock edge with data_val_o && data_rdy_i.
- States:
  - IDLE: on accept with N<=WIDTH, go to STREAM. On accept with N>WIDTH, err_o=1 for the next cycle only, with no data_val_o, and stay in IDLE.
  - STREAM: data_val_o=1. On a consumed word that is not last, load the next word. On a consumed word that is last, return to IDLE.
- Latency: request accepted at edge T gives data_val_o=1 from the cycle after T, with first word F = (1<<N)-1. Throughput is 1 word/cycle while data_rdy_i=1.
- Last word L = F << (WIDTH-N). data_last_o = (data_o == L) while data_val_o=1, else 0.
- Word count per request is C(WIDTH,N).
- Next-word rule (Gosper step), computed in WIDTH+1 bits:
  - c = x & -x
  - r = x + c
  - next = r | (((r ^ x) >> 2) >> ctz(x))
  - ctz comes from a priority encoder; there is no divider.
  - The step is never applied to L, so no carry out of WIDTH is ever registered.
- N=0: single word 0x0, data_last_o=1.
- N=WIDTH: single word all-ones, data_last_o=1.
- Backpressure: while data_val_o && !data_rdy_i, data_o and data_last_o hold stable.
- Back-to-back requests: a request presented during STREAM waits. It is accepted at the earliest in the cycle after the last-word handshake, which has cnt_rdy_o=1 again. There is no request buffering.
- Reset mid-stream: outputs clear immediately (asynchronously). The sequence is abandoned, with no resume.
- Output registers: data_o, data_val_o and err_o are registered. data_last_o is a compare on the registered data_o.

Decomposition:
- Package bit_population_pkg:
  - state enum state_t {IDLE, STREAM}
  - function first_word(N)
  - function last_word(N)
  - function ctz(x)
- Sub-module bit_pattern_next: purely combinational, WIDTH-parameterised Gosper next-permutation (x -> next). Unit-testable on its own.
- Top module: FSM, output registers, handshakes.

Test Plan:
1. WIDTH=8, N=2, data_rdy_i=1 -> 28 words 0x03,0x05,0x06,0x09,...,0xC0. data_last_o only on 0xC0. cnt_rdy_o=1 the cycle after.
2. N=3 with data_rdy_i low for 4 cycles after the second word -> data_o holds 0x0B stable. Then 0x0D, 0x0E, 0x13 follow; 56 words total, all with popcount 3, strictly ascending.
3. N=0 -> single word 0x00 with data_last_o=1. N=8 -> single word 0xFF with data_last_o=1.
4. N=9 -> err_o high for exactly 1 cycle. data_val_o stays 0. cnt_rdy_o stays 1.
5. N=4, assert arst_n_i low after the 5th word -> data_val_o=0 in the same cycle. After release, N=1 yields 0x01,0x02,...,0x80.
6. cnt_val_i held high with N=1, then N=7 queued -> the second request is accepted the cycle after the 0x80 handshake. First word 0x7F, last word 0xFE; no idle gap beyond 1 cycle.
